// File: rtl/arc_microsequencer.sv
// Microprogrammed sequencer for the ARC datapath: addresses the control store,
// holds the current microword in the MIR and stalls/masks it around memory accesses.
module arc_microsequencer #(
  parameter int CS_AW   = 11,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      ir,
  input  logic [3:0]       psr,
  input  logic [40:0]      cs_data,
  input  logic             mem_ready,
  output logic [CS_AW-1:0] cs_addr,
  output logic [40:0]      mir,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic [CS_AW-1:0] upc,
  output logic             fault
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  // C destination + CMUX and ALU code are cleared while a memory access waits.
  localparam logic [40:0] STALL_MASK = {14'b0, 7'h7F, 2'b0, 4'hF, 14'b0};

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [40:0]        mir_reg, mir_next;
  logic [CS_AW-1:0]   upc_reg, upc_next;
  logic [CNT_W-1:0]   stall_cnt_reg, stall_cnt_next;

  logic               stall;
  logic               timeout_hit;
  logic [2:0]         cond;
  logic [CS_AW-1:0]   jaddr;
  logic [CS_AW-1:0]   upc_inc;
  logic [CS_AW-1:0]   decode_addr;
  logic [CS_AW-1:0]   seq_addr;
  logic               unused_ir_bits;

  assign cond        = mir_reg[13:11];
  assign jaddr       = mir_reg[CS_AW-1:0];
  assign upc_inc     = upc_reg + CS_AW'(1);
  assign decode_addr = {1'b1, ir[31:30], ir[24:19], 2'b00};
  assign unused_ir_bits = ^{ir[29:25], ir[18:14], ir[12:0]};

  assign stall       = (state_reg == RUN) && (mir_reg[19] || mir_reg[18]) && !mem_ready;
  assign timeout_hit = (TIMEOUT != 0) && stall && (stall_cnt_reg == CNT_W'(TIMEOUT - 1));

  always_comb begin
    seq_addr = upc_inc;
    case (cond)
      3'd0:    seq_addr = upc_inc;
      3'd1:    seq_addr = psr[3] ? jaddr : upc_inc;
      3'd2:    seq_addr = psr[2] ? jaddr : upc_inc;
      3'd3:    seq_addr = psr[1] ? jaddr : upc_inc;
      3'd4:    seq_addr = psr[0] ? jaddr : upc_inc;
      3'd5:    seq_addr = ir[13] ? jaddr : upc_inc;
      3'd6:    seq_addr = jaddr;
      default: seq_addr = decode_addr;
    endcase
  end

  always_comb begin
    state_next     = state_reg;
    mir_next       = mir_reg;
    upc_next       = upc_reg;
    stall_cnt_next = stall_cnt_reg;
    cs_addr        = '0;
    case (state_reg)
      BOOT: begin
        mir_next       = cs_data;
        upc_next       = '0;
        stall_cnt_next = '0;
        state_next     = RUN;
      end
      RUN: begin
        if (stall) begin
          cs_addr = upc_reg;
          if (timeout_hit) begin
            // Clearing the MIR drops RD/WR so nothing keeps requesting memory.
            mir_next       = '0;
            stall_cnt_next = '0;
            state_next     = FAULT;
          end else begin
            stall_cnt_next = stall_cnt_reg + CNT_W'(1);
          end
        end else begin
          cs_addr        = seq_addr;
          mir_next       = cs_data;
          upc_next       = seq_addr;
          stall_cnt_next = '0;
        end
      end
      FAULT: begin
        cs_addr = '0;
      end
      default: begin
        state_next = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= BOOT;
      mir_reg       <= '0;
      upc_reg       <= '0;
      stall_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      mir_reg       <= mir_next;
      upc_reg       <= upc_next;
      stall_cnt_reg <= stall_cnt_next;
    end
  end

  assign mir    = (state_reg != RUN) ? '0 : (stall ? (mir_reg & ~STALL_MASK) : mir_reg);
  assign mem_rd = mir_reg[19];
  assign mem_wr = mir_reg[18];
  assign upc    = upc_reg;
  assign fault  = (state_reg == FAULT);

endmodule

// File: tb/tb_arc_microsequencer.sv
// Directed bench for arc_microsequencer: a stimulus process queues per-cycle
// expectations and a negedge monitor pops and compares them.
module tb_arc_microsequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ir = '0;
  logic [3:0]  psr = '0;
  logic [40:0] cs_data;
  logic        mem_ready = 1'b1;
  logic [10:0] cs_addr;
  logic [40:0] mir;
  logic        mem_rd, mem_wr;
  logic [10:0] upc;
  logic        fault;

  logic [40:0] cs_mem [0:2047];

  typedef struct packed {
    logic        chk_upc;
    logic [10:0] upc;
    logic [40:0] mir;
    logic [10:0] cs_addr;
    logic        rd;
    logic        wr;
    logic        fault;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  assign cs_data = cs_mem[cs_addr];

  arc_microsequencer #(.CS_AW(11), .TIMEOUT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .ir        (ir),
    .psr       (psr),
    .cs_data   (cs_data),
    .mem_ready (mem_ready),
    .cs_addr   (cs_addr),
    .mir       (mir),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .upc       (upc),
    .fault     (fault)
  );

  // One vector per cycle: drive inputs just after the edge, queue what the
  // outputs must show during that cycle.
  task automatic vec(input logic r, input logic [31:0] i, input logic [3:0] p,
                     input logic mr, input logic cu, input logic [10:0] e_upc,
                     input logic [40:0] e_mir, input logic [10:0] e_cs,
                     input logic e_rd, input logic e_wr, input logic e_f);
    exp_t e;
    @(posedge clk);
    #1;
    rst       = r;
    ir        = i;
    psr       = p;
    mem_ready = mr;
    e.chk_upc = cu;
    e.upc     = e_upc;
    e.mir     = e_mir;
    e.cs_addr = e_cs;
    e.rd      = e_rd;
    e.wr      = e_wr;
    e.fault   = e_f;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic bad;
      e = sb.pop_front();
      n_vec++;
      bad = (mir !== e.mir) || (cs_addr !== e.cs_addr) || (mem_rd !== e.rd) ||
            (mem_wr !== e.wr) || (fault !== e.fault) || (e.chk_upc && (upc !== e.upc));
      if (bad) begin
        n_bad++;
        $display("FAIL vec %0d: got upc=%h mir=%h cs_addr=%h rd=%b wr=%b fault=%b, want upc=%h mir=%h cs_addr=%h rd=%b wr=%b fault=%b",
                 n_vec, upc, mir, cs_addr, mem_rd, mem_wr, fault,
                 e.upc, e.mir, e.cs_addr, e.rd, e.wr, e.fault);
      end else begin
        $display("vec %0d ok: upc=%h mir=%h cs_addr=%h rd=%b wr=%b fault=%b",
                 n_vec, upc, mir, cs_addr, mem_rd, mem_wr, fault);
      end
    end
  end

  initial begin
    for (int a = 0; a < 2048; a++) cs_mem[a] = '0;
    cs_mem[11'h000] = 41'h000_0000_0001;  // COND 0
    cs_mem[11'h001] = 41'h000_0000_1123;  // COND 2 (z) -> 0x123
    cs_mem[11'h123] = 41'h000_0000_1050;  // COND 2 (z) -> 0x050
    cs_mem[11'h124] = 41'h000_0000_0A00;  // COND 1 (n) -> 0x200
    cs_mem[11'h200] = 41'h000_0000_0B00;  // COND 1 (n) -> 0x300
    cs_mem[11'h201] = 41'h000_0000_1B10;  // COND 3 (v) -> 0x310
    cs_mem[11'h310] = 41'h000_0000_1800;  // COND 3 (v) -> 0x000
    cs_mem[11'h311] = 41'h000_0000_2400;  // COND 4 (c) -> 0x400
    cs_mem[11'h400] = 41'h000_0000_2000;  // COND 4 (c) -> 0x000
    cs_mem[11'h401] = 41'h000_0000_2C20;  // COND 5 (ir13) -> 0x420
    cs_mem[11'h420] = 41'h000_0000_2800;  // COND 5 (ir13) -> 0x000
    cs_mem[11'h421] = 41'h000_0000_37FF;  // COND 6 -> 0x7FF
    cs_mem[11'h7FF] = 41'h1F8_0000_0155;  // A=0x3F, COND 0
    cs_mem[11'h002] = 41'h000_0000_3800;  // COND 7 decode
    cs_mem[11'h600] = 41'h000_0000_3800;  // COND 7 decode
    cs_mem[11'h700] = 41'h010_30A8_F010;  // RD, A=2, B=3, C=5, ALU=0011, COND 6 -> 0x010
    cs_mem[11'h010] = 41'h000_00E5_4000;  // WR, C=7, ALU=0101, COND 0
    cs_mem[11'h011] = 41'h000_0028_4000;  // RD, C=1, ALU=0001, COND 0

    //   rst  ir            psr      mr   cu   upc      mir               cs_addr  rd wr f
    vec(1'b1, 32'h0,        4'b0000, 1'b1, 1'b1, 11'h000, 41'h000_0000_0000, 11'h000, 0, 0, 0);
    vec(1'b0, 32'h0,        4'b0000, 1'b1, 1'b1, 11'h000, 41'h000_0000_0000, 11'h000, 0, 0, 0); // BOOT
    vec(1'b0, 32'h0,        4'b0000, 1'b1, 1'b1, 11'h000, 41'h000_0000_0001, 11'h001, 0, 0, 0);
    vec(1'b0, 32'h0,        4'b0100, 1'b1, 1'b1, 11'h001, 41'h000_0000_1123, 11'h123, 0, 0, 0); // z taken
    vec(1'b0, 32'h0,        4'b1011, 1'b1, 1'b1, 11'h123, 41'h000_0000_1050, 11'h124, 0, 0, 0); // z not
    vec(1'b0, 32'h0,        4'b1000, 1'b1, 1'b1, 11'h124, 41'h000_0000_0A00, 11'h200, 0, 0, 0); // n taken
    vec(1'b0, 32'h0,        4'b0111, 1'b1, 1'b1, 11'h200, 41'h000_0000_0B00, 11'h201, 0, 0, 0); // n not
    vec(1'b0, 32'h0,        4'b0010, 1'b1, 1'b1, 11'h201, 41'h000_0000_1B10, 11'h310, 0, 0, 0); // v taken
    vec(1'b0, 32'h0,        4'b1101, 1'b1, 1'b1, 11'h310, 41'h000_0000_1800, 11'h311, 0, 0, 0); // v not
    vec(1'b0, 32'h0,        4'b0001, 1'b1, 1'b1, 11'h311, 41'h000_0000_2400, 11'h400, 0, 0, 0); // c taken
    vec(1'b0, 32'h0,        4'b1110, 1'b1, 1'b1, 11'h400, 41'h000_0000_2000, 11'h401, 0, 0, 0); // c not
    vec(1'b0, 32'h00002000, 4'b0000, 1'b1, 1'b1, 11'h401, 41'h000_0000_2C20, 11'h420, 0, 0, 0); // ir13 taken
    vec(1'b0, 32'hFFFFDFFF, 4'b1111, 1'b1, 1'b1, 11'h420, 41'h000_0000_2800, 11'h421, 0, 0, 0); // ir13 not
    vec(1'b0, 32'h0,        4'b0000, 1'b1, 1'b1, 11'h421, 41'h000_0000_37FF, 11'h7FF, 0, 0, 0); // always
    vec(1'b0, 32'h0,        4'b1111, 1'b1, 1'b1, 11'h7FF, 41'h1F8_0000_0155, 11'h000, 0, 0, 0); // wrap
    vec(1'b0, 32'h0,        4'b0000, 1'b1, 1'b1, 11'h000, 41'h000_0000_0001, 11'h001, 0, 0, 0);
    vec(1'b0, 32'h0,        4'b0000, 1'b1, 1'b1, 11'h001, 41'h000_0000_1123, 11'h002, 0, 0, 0);
    vec(1'b0, 32'h82000000, 4'b0000, 1'b1, 1'b1, 11'h002, 41'h000_0000_3800, 11'h600, 0, 0, 0); // decode
    vec(1'b0, 32'hC0000000, 4'b0000, 1'b1, 1'b1, 11'h600, 41'h000_0000_3800, 11'h700, 0, 0, 0); // decode
    for (int k = 0; k < 3; k++)                                                                 // RD stall
      vec(1'b0, 32'h0,      4'b0000, 1'b0, 1'b1, 11'h700, 41'h010_3008_3010, 11'h700, 1, 0, 0);
    vec(1'b0, 32'h0,        4'b0000, 1'b1, 1'b1, 11'h700, 41'h010_30A8_F010, 11'h010, 1, 0, 0);
    for (int k = 0; k < 3; k++)                                                                 // WR stall
      vec(1'b0, 32'h0,      4'b0000, 1'b0, 1'b1, 11'h010, 41'h000_0004_0000, 11'h010, 0, 1, 0);
    vec(1'b0, 32'h0,        4'b0000, 1'b1, 1'b1, 11'h010, 41'h000_00E5_4000, 11'h011, 0, 1, 0); // ready on 4th
    for (int k = 0; k < 4; k++)                                                                 // timeout run
      vec(1'b0, 32'h0,      4'b0000, 1'b0, 1'b1, 11'h011, 41'h000_0008_0000, 11'h011, 1, 0, 0);
    vec(1'b0, 32'h0,        4'b0000, 1'b0, 1'b0, 11'h000, 41'h000_0000_0000, 11'h000, 0, 0, 1); // FAULT
    vec(1'b0, 32'h0,        4'b0000, 1'b1, 1'b0, 11'h000, 41'h000_0000_0000, 11'h000, 0, 0, 1); // sticky
    vec(1'b1, 32'h0,        4'b0000, 1'b1, 1'b1, 11'h000, 41'h000_0000_0000, 11'h000, 0, 0, 0); // async rst
    vec(1'b0, 32'h0,        4'b0000, 1'b1, 1'b1, 11'h000, 41'h000_0000_0000, 11'h000, 0, 0, 0); // BOOT
    vec(1'b0, 32'h0,        4'b0000, 1'b1, 1'b1, 11'h000, 41'h000_0000_0001, 11'h001, 0, 0, 0);
    vec(1'b0, 32'h0,        4'b0000, 1'b1, 1'b1, 11'h001, 41'h000_0000_1123, 11'h002, 0, 0, 0);

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
